hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central stall/flush scheduler for the 5-stage branch-predicted pipeline.
- Consumes the EX-stage forwarding hazard flag, the EX-stage branch-mispredict signal, the multi-cycle mul/div handshake and the data-memory ready signal.
- Drives per-stage pipeline-register write enables and flushes, plus the PC write enable.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 16, width of the performance counters.
- MULDIV_MAX_CYC, 64, cycles in MULDIV before a timeout abort.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- mem_ex_hazard  in  1  EX instruction needs a value that a load in MEM has not yet produced (load-use)
- ex_mispredict  in  1  branch in EX resolved opposite to prediction; valid only with non-forward-hazard operands
- muldiv_start  in  1  EX holds a multi-cycle mul/div op; pulses on the first EX cycle
- muldiv_done  in  1  mul/div unit result valid (1-cycle pulse)
- dmem_ready  in  1  data memory completes this cycle; 0 means the MEM access is still waiting
- pc_write  out  1  PC register update enable
- ifid_write  out  1  IF/ID register write enable
- idex_write  out  1  ID/EX register write enable
- exmem_write  out  1  EX/MEM register write enable
- memwb_write  out  1  MEM/WB register write enable
- flush_ifid  out  1  load bubble into IF/ID
- flush_idex  out  1  load bubble into ID/EX
- flush_exmem  out  1  load bubble into EX/MEM
- muldiv_timeout  out  1  sticky error: mul/div exceeded MULDIV_MAX_CYC
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  cycles with flush_ifid=1

Behaviour:
- All outputs are combinational from state plus inputs, except the counters and muldiv_timeout, which are registered.
- Reset state: FSM=RUN, counters=0, muldiv_timeout=0, wait counter=0.
- The combinational outputs with no stall condition are: all write enables =1, all flushes =0.
- A flush only loads a bubble when the corresponding write enable is 1.

FSM states: RUN, LU_BUBBLE, MULDIV.

Priority, evaluated every cycle, highest first:
1. dmem_ready=0, any state:
   - Freeze: all write enables =0, all flushes =0.
   - State, wait counter and pending events hold.
   - No counter increments except stall_cnt.
2. State MULDIV:
   - pc_write, ifid_write, idex_write =0; exmem_write=1 with flush_exmem=1 (bubble enters MEM); memwb_write=1.
   - Wait counter increments.
   - On muldiv_done: the same cycle releases (outputs as RUN with no stall), next state RUN.
   - If the wait counter reaches MULDIV_MAX_CYC-1 without done: set muldiv_timeout, release as if done, next state RUN.
3. State RUN, muldiv_start=1:
   - Same outputs as MULDIV; wait counter cleared to 1.
   - Next state MULDIV, unless muldiv_done is also 1 (single-cycle completion), then stay in RUN.
4. State RUN, mem_ex_hazard=1:
   - pc_write, ifid_write, idex_write =0; flush_exmem=1.
   - Next state LU_BUBBLE.
   - ex_mispredict is ignored this cycle, because operands are stale.
5. ex_mispredict=1, in RUN or LU_BUBBLE:
   - pc_write=1 (redirect); flush_ifid=1, flush_idex=1; other enables =1.
6. State LU_BUBBLE:
   - mem_ex_hazard is masked; normal advance.
   - Next state RUN after exactly 1 cycle.
   - A mispredict in this cycle is honoured per rule 5.

Counters:
- stall_cnt increments when pc_write=0.
- flush_cnt increments when flush_ifid=1.
- Both saturate at all-ones; no wrap.

Other rules:
- muldiv_timeout is cleared only by reset.
- Reset asserted mid-MULDIV or mid-freeze returns immediately to RUN with no pending state retained.
- muldiv_start while already in MULDIV is ignored.

Test Plan:
- Load-use: in RUN, pulse mem_ex_hazard for 2 cycles -> cycle 0: pc_write=0, ifid_write=0, idex_write=0, flush_exmem=1; cycle 1 (LU_BUBBLE): all enables =1, flushes =0 despite hazard=1; stall_cnt=1.
- Mispredict vs load-use: assert both in RUN -> no flush_ifid, stall as load-use; next cycle ex_mispredict alone -> flush_ifid=1, flush_idex=1, pc_write=1; flush_cnt=1.
- Mul/div: muldiv_start, then muldiv_done 5 cycles later -> pc_write=0 for 5 cycles, pc_write=1 on the done cycle, flush_exmem=1 on each stall cycle; stall_cnt=5.
- Timeout: MULDIV_MAX_CYC=8, muldiv_start with no done -> released on cycle 7; muldiv_timeout=1 and stays 1 until rst_n=0.
- Memory freeze: dmem_ready=0 for 3 cycles during MULDIV, with muldiv_done pulsed during the freeze -> done ignored, all enables =0, state stays MULDIV, wait counter frozen; resume afterwards.
- Saturation/reset: CNT_W=4, hold mem_ex_hazard alternating for 40 cycles -> stall_cnt stops at 15; async rst_n low mid-MULDIV -> immediately state RUN, counters 0, all enables =1.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Hazard/control bundle between the pipeline datapath and the hazard sequencer.
// slave is the sequencer side; master is the datapath side.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             mem_ex_hazard;
  logic             ex_mispredict;
  logic             muldiv_start;
  logic             muldiv_done;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic             muldiv_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  mem_ex_hazard, ex_mispredict, muldiv_start, muldiv_done, dmem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           flush_ifid, flush_idex, flush_exmem, muldiv_timeout, stall_cnt, flush_cnt
  );

  modport master (
    output mem_ex_hazard, ex_mispredict, muldiv_start, muldiv_done, dmem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           flush_ifid, flush_idex, flush_exmem, muldiv_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, mispredict
// flushes, mul/div hold with timeout, memory freeze, and saturating perf counters.
//
//   state     | meaning
//   RUN       | normal issue; hazards and mul/div starts are accepted here
//   LU_BUBBLE | one cycle after a load-use stall; hazard flag masked
//   MULDIV    | front end held while the mul/div unit works
module hazard_sequencer #(
  parameter int CNT_W          = 16,
  parameter int MULDIV_MAX_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_sequencer_if.slave   bus
);
  localparam int                WAIT_W    = $clog2(MULDIV_MAX_CYC) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULDIV_MAX_CYC - 1);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MULDIV} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic fl_ifid, fl_idex, fl_exmem;
  logic hold_front;
  logic redirect;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q;
    hold_front = 1'b0;
    redirect   = 1'b0;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    fl_ifid    = 1'b0;
    fl_idex    = 1'b0;
    fl_exmem   = 1'b0;

    if (!bus.dmem_ready) begin
      // Whole pipeline frozen; every pending event waits for memory.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else begin
      case (state_q)
        MULDIV: begin
          if (bus.muldiv_done) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = RUN;
            wait_d    = '0;
          end else begin
            hold_front = 1'b1;
            wait_d     = wait_q + 1'b1;
          end
        end
        RUN: begin
          if (bus.muldiv_start) begin
            wait_d = WAIT_W'(1);
            if (!bus.muldiv_done) begin
              hold_front = 1'b1;
              state_d    = MULDIV;
            end
          end else if (bus.mem_ex_hazard) begin
            hold_front = 1'b1;
            state_d    = LU_BUBBLE;
          end else begin
            redirect = bus.ex_mispredict;
          end
        end
        LU_BUBBLE: begin
          state_d  = RUN;
          redirect = bus.ex_mispredict;
        end
        default: state_d = RUN;
      endcase

      if (hold_front) begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        fl_exmem = 1'b1;
      end
      if (redirect) begin
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (!pc_we && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (fl_ifid && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_write       = pc_we;
  assign bus.ifid_write     = ifid_we;
  assign bus.idex_write     = idex_we;
  assign bus.exmem_write    = exmem_we;
  assign bus.memwb_write    = memwb_we;
  assign bus.flush_ifid     = fl_ifid;
  assign bus.flush_idex     = fl_idex;
  assign bus.flush_exmem    = fl_exmem;
  assign bus.muldiv_timeout = timeout_q;
  assign bus.stall_cnt      = stall_q;
  assign bus.flush_cnt      = flush_q;
endmodule
